// File: rtl/mdu_sequencer.sv
// Iterative signed multiply/divide unit: one result bit per clock over WIDTH ITER cycles,
// followed by a FIX cycle that applies the sign correction and loads Hi/Lo.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  typedef struct packed {
    logic             op;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_b;
  } req_t;

  state_t           state;
  req_t             req;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] wh, wl;

  // Magnitudes are unsigned WIDTH bits, so the most negative operand maps to 2^(WIDTH-1).
  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  assign mag_a_in = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign mag_b_in = B[WIDTH-1] ? (~B + 1'b1) : B;

  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] nxt_h, nxt_l;

  // MUL: shift-add with wl holding the multiplier bits; DIV: restoring, wl holds dividend/quotient.
  always_comb begin
    mul_sum  = {1'b0, wh} + ({1'b0, req.mag_b} & {(WIDTH+1){wl[0]}});
    div_sh   = {wh, wl[WIDTH-1]};
    div_diff = div_sh - {1'b0, req.mag_b};
    div_ge   = (div_sh >= {1'b0, req.mag_b});
    if (req.op) begin
      nxt_h = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      nxt_l = {wl[WIDTH-2:0], div_ge};
    end else begin
      nxt_h = mul_sum[WIDTH:1];
      nxt_l = {mul_sum[0], wl[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_h, fix_l;

  always_comb begin
    prod_fix = (req.neg_a ^ req.neg_b) ? (~{wh, wl} + 1'b1) : {wh, wl};
    if (req.op) begin
      fix_l = (req.neg_a ^ req.neg_b) ? (~wl + 1'b1) : wl;
      fix_h = req.neg_a ? (~wh + 1'b1) : wh;
    end else begin
      fix_l = prod_fix[WIDTH-1:0];
      fix_h = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      req     <= '0;
      count   <= '0;
      wh      <= '0;
      wl      <= '0;
      Hi      <= '0;
      Lo      <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          req     <= '{op: Op, neg_a: A[WIDTH-1], neg_b: B[WIDTH-1], mag_b: mag_b_in};
          count   <= '0;
          DivZero <= 1'b0;
          if (Op && (B == '0)) begin
            Hi      <= A;
            Lo      <= '1;
            DivZero <= 1'b1;
            Done    <= 1'b1;
            state   <= DONE;
          end else begin
            wh    <= '0;
            wl    <= mag_a_in;
            Busy  <= 1'b1;
            state <= ITER;
          end
        end
        ITER: begin
          wh    <= nxt_h;
          wl    <= nxt_l;
          count <= count + 1'b1;
          if (count == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          Hi    <= fix_h;
          Lo    <= fix_l;
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed and random checks of mdu_sequencer against a 64-bit arithmetic reference model.
module tb_mdu_sequencer;
  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic         Op    = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic [W-1:0] Hi, Lo;
  logic         Busy, Done, DivZero;

  int errors = 0;
  int checks = 0;

  mdu_sequencer #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic; SV / and % truncate toward zero.
  function automatic void model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == '0) begin
      hi = a;
      lo = '1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit spurious, input string tag);
    logic [W-1:0] eh, el, hh, ll;
    int  busy_n, done_n, done_at;
    bit  dz;
    logic dzv;
    busy_n = 0; done_n = 0; done_at = -1; hh = 'x; ll = 'x; dzv = 1'bx;
    model(op, a, b, eh, el);
    dz = op && (b == '0);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clock); #1;
    Start = 1'b0; A = $urandom; B = $urandom; Op = 1'($urandom);
    for (int k = 0; k < 60; k++) begin
      if (Busy) busy_n++;
      if (Done) begin
        done_n++;
        if (done_at < 0) begin done_at = k; hh = Hi; ll = Lo; dzv = DivZero; end
      end
      if (done_at >= 0 && k == done_at + 1) break;
      if (spurious && (k == 5 || k == 20)) begin
        Start = 1'b1; Op = ~op; A = $urandom; B = $urandom;
      end else Start = 1'b0;
      @(posedge Clock); #1;
    end
    Start = 1'b0;
    chk({tag, ".done_at"}, 64'(done_at), dz ? 64'd0 : 64'(W + 1));
    chk({tag, ".done_n"},  64'(done_n), 64'd1);
    chk({tag, ".busy_n"},  64'(busy_n), dz ? 64'd0 : 64'(W + 1));
    chk({tag, ".hi"},      64'(hh), 64'(eh));
    chk({tag, ".lo"},      64'(ll), 64'(el));
    chk({tag, ".divzero"}, 64'(dzv), 64'(dz));
    chk({tag, ".hold"},    {Hi, Lo}, {eh, el});
  endtask

  initial begin
    logic         rop;
    logic [W-1:0] ra, rb;
    int           busy_n, done_n;

    repeat (2) @(posedge Clock);
    #1;
    chk("reset.hi", 64'(Hi), 64'd0);
    chk("reset.lo", 64'(Lo), 64'd0);
    chk("reset.flags", {61'd0, Busy, Done, DivZero}, 64'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;

    run_op(1'b0, 32'd7,        32'hFFFFFFFD, 1'b0, "mul7x-3");
    run_op(1'b0, 32'h80000000, 32'h80000000, 1'b0, "mulmin");
    run_op(1'b0, 32'hFFFFFFFF, 32'd1,        1'b0, "mul-1x1");
    run_op(1'b1, 32'hFFFFFFF9, 32'd2,        1'b0, "div-7/2");
    run_op(1'b1, 32'd100,      32'hFFFFFFF9, 1'b0, "div100/-7");
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, "divmin/-1");
    run_op(1'b1, 32'd5,        32'd0,        1'b0, "div5/0");
    run_op(1'b0, 32'd2,        32'd3,        1'b0, "mul2x3");
    run_op(1'b0, 32'h12345678, 32'hFEDCBA98, 1'b1, "mul_spur");
    run_op(1'b1, 32'h89ABCDEF, 32'd12345,    1'b1, "div_spur");

    for (int i = 0; i < 16; i++) begin
      rop = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: ra = '1;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'd1;
        2: rb = '1;
        3: rb = 32'h80000000;
        4: rb = $urandom_range(1, 100);
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 1'b0, $sformatf("rand%0d", i));
    end

    // Abort a DIV mid-iteration while Hi/Lo hold the previous result.
    Start = 1'b1; Op = 1'b1; A = 32'hFFFFFF9C; B = 32'd7;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    chk("abort.hi", 64'(Hi), 64'd0);
    chk("abort.lo", 64'(Lo), 64'd0);
    chk("abort.flags", {61'd0, Busy, Done, DivZero}, 64'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    busy_n = 0; done_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (Busy) busy_n++;
      if (Done) done_n++;
      @(posedge Clock); #1;
    end
    chk("abort.busy_after", 64'(busy_n), 64'd0);
    chk("abort.done_after", 64'(done_n), 64'd0);
    run_op(1'b1, 32'd9, 32'd4, 1'b0, "div9/4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
